rx_gearbox_slip: RTL and testbench
==================================

Name: rx_gearbox_slip

Overview:
- Receive-side 32→66 gearbox directly upstream of the 64b/66b block-lock FSM.
- Packs the transceiver's parallel word stream into 66-bit blocks, presented as a 2-bit sync header plus a 64-bit payload.
- blk_vld drives the lock FSM's enable; sh drives its 2-bit header input.
- A slip pulse from the lock FSM discards exactly one received bit, shifting block alignment by one bit position.

Parameters:
- DW, 32, input word width; legal values 16, 32, 64.
- BW, 66, block width (fixed); header = 2 bits, payload = BW-2.

Ports:
- clk  in  1  rising-edge clock, only clock.
- rst_n  in  1  synchronous active-low reset, sampled on clk.
- din  in  DW  received word; din[0] is the earliest bit on the line.
- din_vld  in  1  din is valid this cycle; may have arbitrary gaps.
- slip  in  1  single-cycle request to drop one bit (from lock FSM slid_vld).
- blk_vld  out  1  registered; one-cycle pulse per assembled block.
- sh  out  2  block bits [1:0]; bit0 = first received bit.
- payload  out  64  block bits [65:2].
- slip_ack  out  1  registered one-cycle pulse when a requested bit has been dropped.

Behaviour:
- State: bit buffer buf of width BW+DW, LSB = oldest bit; count cnt (0..BW+DW-1); slip_pend flag.
- Reset (rst_n=0 at a clk edge): cnt=0, buf=0, slip_pend=0, blk_vld=0, sh=0, payload=0, slip_ack=0. Reset mid-block discards all partial bits; nothing is emitted for them.
- Per cycle, combinational order:
  - (1) Append: if din_vld, din is placed at buf[cnt +: DW] and avail = cnt+DW; otherwise avail = cnt.
  - (2) Slip: if (slip or slip_pend) and avail ≥ 1, shift right by 1, decrement avail by 1, clear slip_pend, and assert slip_ack next cycle. If avail = 0, set or hold slip_pend.
  - (3) Extract: if avail ≥ 66, register bits [65:0] onto sh/payload, assert blk_vld next cycle, shift right by 66 and decrement avail by 66.
  - (4) cnt <= avail.
- At most one block per cycle. After extraction cnt ≤ 65 holds for all legal DW, so the buffer never overflows.
- Latency: blk_vld/sh/payload are valid the cycle after the input word completing the block is accepted.
- sh/payload hold their last value when blk_vld = 0.
- A slip arriving while slip_pend = 1 is dropped (no queuing beyond one).
- slip and extraction in the same cycle: the slip is applied first, so that block is already realigned.
- slip_ack and blk_vld may assert in the same cycle.
- Steady state, DW=32: 16 blocks per 33 valid input words; DW=64: 32 blocks per 33 words.
- No FSM beyond slip_pend. All arithmetic is unsigned; cnt width is $clog2(BW+DW).

Test Plan:
- Aligned stream, DW=32, blocks with sh=2'b01 and payload=incrementing 64'h1,2,3…:
  - 33 contiguous din_vld words → exactly 16 blk_vld pulses.
  - First pulse is the cycle after the 3rd word.
  - All sh=01, payloads in order.
- Same stream prefixed with 5 junk bits:
  - Issue slip 5 times, spaced ≥ 8 cycles apart.
  - 5 slip_ack pulses.
  - Every block after the 5th ack has sh=01 and correct payload.
- din_vld toggling 1-0-1-0:
  - Block content is identical to the contiguous case.
  - blk_vld appears only the cycle after a valid word.
- slip asserted right after reset with din_vld=0 for 10 cycles:
  - slip_pend holds; no slip_ack.
  - First valid word → slip_ack next cycle, cnt = DW-1.
  - A second slip during pending produces no second ack.
- slip coincident with the cycle that completes a block:
  - Emitted block is the 66 bits starting one bit later.
  - slip_ack and blk_vld are both high on the next cycle.
- rst_n low for 1 cycle mid-block (cnt=40):
  - Next cycle all outputs are 0 and cnt=0.
  - After reset, the first block is emitted after 3 new words, with no stale bits.

Source files
------------

// File: rtl/rx_gearbox_slip.sv
// 32->66 receive gearbox with single-bit slip; block out one cycle after the completing word.
// No backpressure: din is accepted whenever din_vld is high, and at most one block is emitted per cycle.
module rx_gearbox_slip #(
  parameter int DW = 32,
  parameter int BW = 66
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          slip,
  output logic          blk_vld,
  output logic [1:0]    sh,
  output logic [BW-3:0] payload,
  output logic          slip_ack
);

  localparam int BFW = BW + DW;
  localparam int CW  = $clog2(BFW);
  localparam int AW  = CW + 1;

  logic [BFW-1:0] bit_buf, buf_a, buf_s, buf_n;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  avail_a, avail_s, avail_n;
  logic           slip_pend, pend_n, ack_n, blk_n;

  // Bits above cnt are always zero, so a new word can simply be OR-ed in.
  always_comb begin
    buf_a   = bit_buf;
    avail_a = AW'(cnt);
    if (din_vld) begin
      buf_a   = bit_buf | (BFW'(din) << cnt);
      avail_a = AW'(cnt) + AW'(DW);
    end

    buf_s   = buf_a;
    avail_s = avail_a;
    pend_n  = slip_pend;
    ack_n   = 1'b0;
    if (slip || slip_pend) begin
      if (avail_a != '0) begin
        buf_s   = buf_a >> 1;
        avail_s = avail_a - AW'(1);
        pend_n  = 1'b0;
        ack_n   = 1'b1;
      end else begin
        pend_n  = 1'b1;
      end
    end

    buf_n   = buf_s;
    avail_n = avail_s;
    blk_n   = 1'b0;
    if (avail_s >= AW'(BW)) begin
      buf_n   = buf_s >> BW;
      avail_n = avail_s - AW'(BW);
      blk_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_buf   <= '0;
      cnt       <= '0;
      slip_pend <= 1'b0;
      slip_ack  <= 1'b0;
      blk_vld   <= 1'b0;
      sh        <= '0;
      payload   <= '0;
    end else begin
      bit_buf   <= buf_n;
      cnt       <= avail_n[CW-1:0];
      slip_pend <= pend_n;
      slip_ack  <= ack_n;
      blk_vld   <= blk_n;
      if (blk_n) begin
        sh      <= buf_s[1:0];
        payload <= buf_s[BW-1:2];
      end
    end
  end

endmodule

// File: tb/tb_rx_gearbox_slip.sv
// Bench for rx_gearbox_slip: scenario table plus hand sequences, checked against a bit-queue model.
module tb_rx_gearbox_slip;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, din_vld, slip;
  logic [DW-1:0] din;
  logic          blk_vld, slip_ack;
  logic [1:0]    sh;
  logic [63:0]   payload;

  always #5 clk = ~clk;

  rx_gearbox_slip #(.DW(DW), .BW(66)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .slip(slip),
    .blk_vld(blk_vld), .sh(sh), .payload(payload), .slip_ack(slip_ack)
  );

  int vectors = 0, miscompares = 0;

  // Reference: the line as an ordered queue of bits, oldest at the front.
  bit          mq[$];
  bit          m_pend;
  logic        m_bv, m_ack;
  logic [1:0]  m_sh;
  logic [63:0] m_pl;
  logic [65:0] m_blk;
  bit          stream[$];

  typedef struct {
    int junk; bit gap; bit rnd; int nwords; int nslip; int exp_blocks; int exp_acks;
  } scen_t;
  scen_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [DW-1:0] d, input bit s);
    if (!r) begin
      mq.delete(); m_pend = 0; m_bv = 0; m_ack = 0; m_sh = '0; m_pl = '0;
      return;
    end
    if (v) for (int i = 0; i < DW; i++) mq.push_back(d[i]);
    m_ack = 0;
    if (s || m_pend) begin
      if (mq.size() > 0) begin void'(mq.pop_front()); m_ack = 1; m_pend = 0; end
      else m_pend = 1;
    end
    m_bv = 0;
    if (mq.size() >= 66) begin
      for (int i = 0; i < 66; i++) m_blk[i] = mq.pop_front();
      m_bv = 1; m_sh = m_blk[1:0]; m_pl = m_blk[65:2];
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit s);
    rst_n = r; din_vld = v; din = d; slip = s;
    @(posedge clk);
    model(r, v, d, s);
    @(negedge clk);
    chk("blk_vld", 64'(blk_vld), 64'(m_bv));
    chk("slip_ack", 64'(slip_ack), 64'(m_ack));
    chk("sh", 64'(sh), 64'(m_sh));
    chk("payload", payload, m_pl);
    chk("cnt", 64'(dut.cnt), 64'(mq.size()));
  endtask

  function automatic logic [DW-1:0] next_word();
    logic [DW-1:0] w;
    w = DW'($urandom);
    for (int i = 0; i < DW; i++) if (stream.size() > 0) w[i] = stream.pop_front();
    return w;
  endfunction

  task automatic build(input int junk, input int nblocks);
    logic [63:0] p;
    stream.delete();
    for (int i = 0; i < junk; i++) stream.push_back(bit'($urandom_range(0, 1)));
    for (int k = 0; k < nblocks; k++) begin
      p = 64'(k + 1);
      stream.push_back(1'b1); stream.push_back(1'b0);
      for (int i = 0; i < 64; i++) stream.push_back(p[i]);
    end
  endtask

  task automatic run(input scen_t sc);
    int w, t, blocks, acks, slips, first_w;
    bit v, s, prev_v;
    w = 0; t = 0; blocks = 0; acks = 0; slips = 0; first_w = -1; prev_v = 0;
    if (sc.rnd) stream.delete();
    else build(sc.junk, (sc.nwords * DW) / 66 + 1);
    step(0, 0, '0, 0);
    while (w < sc.nwords) begin
      if (sc.gap) v = (t % 2 == 0);
      else if (sc.rnd) v = bit'($urandom_range(0, 1));
      else v = 1;
      if (sc.rnd) s = ($urandom_range(0, 5) == 0);
      else begin
        s = (slips < sc.nslip) && (t % 8 == 0);
        if (s) slips++;
      end
      if (v) w++;
      step(1, v, v ? next_word() : DW'($urandom), s);
      if (slip_ack) acks++;
      if (blk_vld) begin
        blocks++;
        if (first_w < 0) first_w = w;
        chk("blk_after_vld", 64'(v), 64'd1);
        if (!sc.rnd && acks == sc.nslip) begin
          chk("aligned_sh", 64'(sh), 64'd1);
          chk("aligned_pl", payload, 64'(blocks));
        end
      end
      prev_v = v;
      t++;
    end
    if (!sc.rnd && sc.nslip == 0) chk("first_blk_word", 64'(first_w), 64'd3);
    if (sc.exp_blocks >= 0) begin
      chk("block_count", 64'(blocks), 64'(sc.exp_blocks));
      chk("ack_count", 64'(acks), 64'(sc.exp_acks));
    end
  endtask

  initial begin
    logic [95:0] b;
    int j;
    rst_n = 0; din_vld = 0; slip = 0; din = '0;

    j = $urandom_range(1, 7);
    tbl[0] = '{junk: 0, gap: 0, rnd: 0, nwords: 33, nslip: 0, exp_blocks: 16, exp_acks: 0};
    tbl[1] = '{junk: 5, gap: 0, rnd: 0, nwords: 66, nslip: 5, exp_blocks: 31, exp_acks: 5};
    tbl[2] = '{junk: 0, gap: 1, rnd: 0, nwords: 33, nslip: 0, exp_blocks: 16, exp_acks: 0};
    tbl[3] = '{junk: 3, gap: 1, rnd: 0, nwords: 66, nslip: 3, exp_blocks: 31, exp_acks: 3};
    tbl[4] = '{junk: j, gap: bit'($urandom_range(0, 1)), rnd: 0, nwords: 40, nslip: j,
               exp_blocks: (40 * DW - j) / 66, exp_acks: j};
    tbl[5] = '{junk: 0, gap: 0, rnd: 1, nwords: 200, nslip: 0, exp_blocks: -1, exp_acks: 0};

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Slip requested while the buffer is empty: held pending, a second request is absorbed.
    step(0, 0, '0, 0);
    step(1, 0, '0, 1);
    chk("pend_set", 64'(dut.slip_pend), 64'd1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
    step(1, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
    chk("pend_hold", 64'(dut.slip_pend), 64'd1);
    chk("pend_no_ack", 64'(slip_ack), 64'd0);
    step(1, 1, DW'($urandom), 0);
    chk("pend_ack", 64'(slip_ack), 64'd1);
    chk("pend_cnt", 64'(dut.cnt), 64'(DW - 1));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0, 0);
      chk("no_second_ack", 64'(slip_ack), 64'd0);
    end

    // Slip on the cycle that completes a block: the block starts one bit later.
    b = {$urandom, $urandom, $urandom};
    step(0, 0, '0, 0);
    step(1, 1, b[31:0], 0);
    step(1, 1, b[63:32], 0);
    step(1, 1, b[95:64], 1);
    chk("coinc_blk", 64'(blk_vld), 64'd1);
    chk("coinc_ack", 64'(slip_ack), 64'd1);
    chk("coinc_sh", 64'(sh), 64'(b[2:1]));
    chk("coinc_pl", payload, b[66:3]);

    // Reset with 40 bits buffered discards them.
    step(0, 0, '0, 0);
    for (int i = 0; i < 26; i++) step(1, 1, DW'($urandom), 0);
    chk("mid_cnt", 64'(dut.cnt), 64'd40);
    step(0, 1, DW'($urandom), 1);
    chk("rst_blk", 64'(blk_vld), 64'd0);
    chk("rst_ack", 64'(slip_ack), 64'd0);
    chk("rst_sh", 64'(sh), 64'd0);
    chk("rst_pl", payload, 64'd0);
    chk("rst_cnt", 64'(dut.cnt), 64'd0);
    b = {$urandom, $urandom, $urandom};
    step(1, 1, b[31:0], 0);
    step(1, 1, b[63:32], 0);
    chk("post_rst_early", 64'(blk_vld), 64'd0);
    step(1, 1, b[95:64], 0);
    chk("post_rst_blk", 64'(blk_vld), 64'd1);
    chk("post_rst_sh", 64'(sh), 64'(b[1:0]));
    chk("post_rst_pl", payload, b[65:2]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
